// File: rtl/adder8_pkg.sv
// adder8_pkg -- shared constants and types for the adder8 block.
//   DATA_W : default operand/result width, used as adder8's WIDTH default
//   data_t : DATA_W-bit unsigned data word
package adder8_pkg;

    localparam int DATA_W = 8;

    typedef logic [DATA_W-1:0] data_t;

endpackage : adder8_pkg

// File: rtl/adder8_full_adder.sv
// full_adder -- single-bit full adder cell, one link of the ripple chain.
//   a, b : operand bits
//   cin  : carry from the next-lower bit
//   s    : sum bit
//   cout : carry to the next-higher bit
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic p;

    // Propagate term is shared between the sum and the carry.
    assign p    = a ^ b;
    assign s    = p ^ cin;
    assign cout = (a & b) | (cin & p);

endmodule : full_adder

// File: rtl/adder8.sv
// adder8 -- registered unsigned adder with carry-out and signed overflow.
//   clk   : clock, all state changes on the rising edge
//   rst_n : synchronous active-low reset, clears out/carry/ovf
//   in0   : first operand, WIDTH bits
//   in1   : second operand, WIDTH bits
//   out   : registered (in0 + in1) mod 2^WIDTH
//   carry : registered carry-out of that addition
//   ovf   : registered two's-complement overflow of that addition
// The sum is a combinational ripple chain of full_adder cells; only the
// three outputs are registered, giving exactly one edge of latency.
module adder8
    import adder8_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    output logic [WIDTH-1:0] out,
    output logic             carry,
    output logic             ovf
);

    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;
    logic             ovf_d;

    assign c[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        full_adder u_fa (
            .a   (in0[i]),
            .b   (in1[i]),
            .cin (c[i]),
            .s   (s[i]),
            .cout(c[i+1])
        );
    end

    // Overflow: operands share a sign and the result sign disagrees.
    assign ovf_d = (in0[WIDTH-1] == in1[WIDTH-1]) && (s[WIDTH-1] != in0[WIDTH-1]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out   <= '0;
            carry <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            out   <= s;
            carry <= c[WIDTH];
            ovf   <= ovf_d;
        end
    end

endmodule : adder8

// File: tb/tb_adder8.sv
module tb_adder8;
    import adder8_pkg::*;

    logic  clk = 1'b0;
    logic  rst_n;
    data_t in0, in1, out;
    logic  carry, ovf;

    int total = 0;
    int bad   = 0;

    adder8 #(.WIDTH(DATA_W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .in0  (in0),
        .in1  (in1),
        .out  (out),
        .carry(carry),
        .ovf  (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        data_t a;
        data_t b;
        data_t s;
        logic  c;
        logic  v;
    } vec_t;

    vec_t vecs[10];

    // Compare the {carry, ovf, out} triple against an expected triple.
    task automatic chk(input string nm, input data_t es, input logic ec, input logic ev);
        total++;
        if (out !== es || carry !== ec || ovf !== ev) begin
            bad++;
            $display("FAIL %s: got out=%02h carry=%b ovf=%b want out=%02h carry=%b ovf=%b",
                     nm, out, carry, ovf, es, ec, ev);
        end
    endtask

    initial begin
        vecs[0] = '{8'h05, 8'h04, 8'h09, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
        vecs[3] = '{8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
        vecs[4] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[5] = '{8'hFF, 8'hFF, 8'hFE, 1'b1, 1'b0};
        vecs[6] = '{8'h3C, 8'hC4, 8'h00, 1'b1, 1'b0};
        vecs[7] = '{8'h40, 8'h40, 8'h80, 1'b0, 1'b1};
        vecs[8] = '{8'hA0, 8'h90, 8'h30, 1'b1, 1'b1};
        vecs[9] = '{8'h12, 8'h34, 8'h46, 1'b0, 1'b0};

        // Reset held for two edges with non-zero operands.
        rst_n = 1'b0;
        in0   = 8'hAA;
        in1   = 8'h55;
        repeat (2) @(posedge clk);
        #1 chk("reset", 8'h00, 1'b0, 1'b0);

        // Basic add applied mid-cycle: no change before the edge.
        @(negedge clk);
        rst_n = 1'b1;
        in0   = 8'h05;
        in1   = 8'h04;
        #1 chk("basic_before_edge", 8'h00, 1'b0, 1'b0);
        @(posedge clk);
        #1 chk("basic_after_edge", 8'h09, 1'b0, 1'b0);

        // Operand change between edges leaves the outputs alone.
        in0 = 8'hF0;
        in1 = 8'hF0;
        #2 chk("stable_between_edges", 8'h09, 1'b0, 1'b0);

        // Table vectors on consecutive edges; each lands one edge later.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in0 = vecs[i].a;
            in1 = vecs[i].b;
            @(posedge clk);
            #1 chk($sformatf("vec%0d", i), vecs[i].s, vecs[i].c, vecs[i].v);
        end

        // Mid-run reset: asserted between edges, takes effect only at the edge.
        @(negedge clk);
        rst_n = 1'b0;
        in0   = 8'hC8;
        in1   = 8'h64;
        #1 chk("rst_between_edges", 8'h46, 1'b0, 1'b0);
        @(posedge clk);
        #1 chk("rst_midrun", 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        in0   = 8'h01;
        in1   = 8'h02;
        @(posedge clk);
        #1 chk("rst_resume", 8'h03, 1'b0, 1'b0);

        // Random pairs against an arithmetic reference model.
        for (int i = 0; i < 1000; i++) begin
            logic [8:0] ref_sum;
            int         sref;
            logic       ref_v;
            @(negedge clk);
            in0     = data_t'($urandom_range(0, 255));
            in1     = data_t'($urandom_range(0, 255));
            ref_sum = {1'b0, in0} + {1'b0, in1};
            sref    = int'($signed(in0)) + int'($signed(in1));
            ref_v   = (sref > 127) || (sref < -128);
            @(posedge clk);
            #1 chk($sformatf("rand%0d", i), ref_sum[7:0], ref_sum[8], ref_v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_adder8

// File: doc/adder8.md
ADDER8 -- requirements
Module: adder8

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning operand and result width in bits; all checks below use WIDTH=8.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit, the reset: synchronous and active-low.
REQ-004 The block SHALL have port in0, input, WIDTH bits, the first unsigned operand.
REQ-005 The block SHALL have port in1, input, WIDTH bits, the second unsigned operand.
REQ-006 The block SHALL have port out, output, WIDTH bits, the registered sum.
REQ-007 The block SHALL have port carry, output, 1 bit, the registered carry-out of the same addition as out.
REQ-008 The block SHALL have port ovf, output, 1 bit, the registered two's-complement overflow flag of the same addition.

Function
REQ-009 On each rising clk edge with rst_n high, the block SHALL register out = (in0 + in1) mod 2^WIDTH, using the in0/in1 values present at that edge.
REQ-010 Latency SHALL be exactly one clock edge; out, carry and ovf SHALL remain stable between edges.
REQ-011 carry SHALL equal bit WIDTH of the (WIDTH+1)-bit unsigned sum.
REQ-012 ovf SHALL be 1 when in0 and in1 have the same MSB and the sum MSB differs from it; otherwise 0.
REQ-013 Wrap-around SHALL be silent: 8'hFF + 8'h01 gives out = 8'h00, carry = 1, ovf = 0.
REQ-014 The adder SHALL have no enable, valid or handshake; a new result SHALL be produced on every non-reset edge.
REQ-015 The datapath SHALL be a ripple-carry chain of 1-bit full adders with carry-in tied to 0.
REQ-016 Operand changes between edges SHALL NOT affect the outputs until the next rising edge.

Reset
REQ-017 When rst_n is low at a rising clk edge, out, carry and ovf SHALL all become 0, regardless of the operand values.
REQ-018 Reset SHALL be sampled only on clk edges; asserting rst_n low between edges SHALL NOT change the outputs before the next edge.
REQ-019 On the first edge with rst_n high after reset, the block SHALL produce the sum of the operands present at that edge; there is no pipeline flush delay.
REQ-020 Before the first clk edge, the outputs SHALL be treated as undefined; the testbench SHALL apply reset before checking.

Structure
REQ-021 A shared package adder8_pkg SHALL hold the default width constant (DATA_W = 8), which is used as the WIDTH default.
REQ-022 The package SHALL also hold a typedef for the WIDTH-bit data word.
REQ-023 The block SHALL use one sub-module, full_adder, with ports a, b, cin, s and cout.
REQ-024 adder8 SHALL instantiate WIDTH copies of full_adder in a generate loop and SHALL hold only the output registers.

Verification
REQ-025 Reset: rst_n=0 for 2 edges with in0=8'hAA and in1=8'h55 -> out=8'h00, carry=0, ovf=0.
REQ-026 Basic add: in0=8'h05, in1=8'h04, applied mid-cycle -> out=8'h09, carry=0, ovf=0 after the next rising edge, and not before it.
REQ-027 Wrap-around: in0=8'hFF, in1=8'h01 -> out=8'h00, carry=1, ovf=0 one edge later.
REQ-028 Signed overflow: in0=8'h7F, in1=8'h01 -> out=8'h80, carry=0, ovf=1; and in0=8'h80, in1=8'h80 -> out=8'h00, carry=1, ovf=1.
REQ-029 Back-to-back operands: new operands on consecutive edges -> each result appears exactly one edge later, with none dropped.
REQ-030 Mid-run reset and random check: rst_n low for one edge during traffic -> outputs are 0 on that edge and resume on the next; then 1000 random pairs -> match a reference model of {carry, out} = in0 + in1.
